// File: rtl/i2c_host_pkg.sv
// Shared types and constants for the I2C host reader: FSM states, bit phases
// and the R/W bit values appended to the 7-bit device address.
package i2c_host_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RSTART,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    // Which byte the write path is currently sending.
    typedef enum logic [1:0] {
        WR_DEV_W,
        WR_REG,
        WR_DEV_R
    } wr_sel_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period timebase: counts CLK_DIV clocks per quarter and steps the
// 2-bit SCL phase at the end of each quarter.
module i2c_tick_gen
    import i2c_host_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else if (en) begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_host_reader.sv
// I2C master: START, device address + register write, repeated START,
// N-byte read streamed out with a valid strobe, STOP.
module i2c_host_reader
    import i2c_host_pkg::*;
#(
    parameter int CLK_DIV = 125,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] rd_len,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             scl_oe,
    output logic             busy,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             nack
);

    state_t           state, state_nxt;
    wr_sel_t          wr_sel;
    logic             tick;
    logic [1:0]       phase;
    logic             bit_end, smp;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [LEN_W-1:0] rem;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             ack_bit;
    logic             sda_drv, scl_drv;

    assign busy    = (state != ST_IDLE) && (state != ST_DONE);
    assign done    = (state == ST_DONE);
    assign bit_end = tick && (phase == Q3);
    assign smp     = tick && (phase == Q2);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .clr   (!busy),
        .tick  (tick),
        .phase (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        sda_drv   = 1'b0;
        scl_drv   = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_START;
            ST_START: begin
                sda_drv = phase[1];
                scl_drv = (phase == Q3);
                if (bit_end) state_nxt = ST_WR_BYTE;
            end
            ST_WR_BYTE: begin
                sda_drv = ~shift[7];
                scl_drv = ~phase[1];
                if (bit_end && bit_cnt == 3'd7) state_nxt = ST_WR_ACK;
            end
            ST_WR_ACK: begin
                scl_drv = ~phase[1];
                if (bit_end) begin
                    if (ack_bit) state_nxt = ST_STOP;
                    else begin
                        unique case (wr_sel)
                            WR_DEV_W: state_nxt = ST_WR_BYTE;
                            WR_REG:   state_nxt = (rem == '0) ? ST_STOP : ST_RSTART;
                            default:  state_nxt = ST_RD_BYTE;
                        endcase
                    end
                end
            end
            ST_RSTART: begin
                // Release SDA with SCL low, raise SCL, then pull SDA low while SCL is high.
                sda_drv = phase[1];
                scl_drv = (phase == Q0) || (phase == Q3);
                if (bit_end) state_nxt = ST_WR_BYTE;
            end
            ST_RD_BYTE: begin
                scl_drv = ~phase[1];
                if (bit_end && bit_cnt == 3'd7) state_nxt = ST_RD_ACK;
            end
            ST_RD_ACK: begin
                sda_drv = (rem > LEN_W'(1));
                scl_drv = ~phase[1];
                if (bit_end) state_nxt = (rem > LEN_W'(1)) ? ST_RD_BYTE : ST_STOP;
            end
            ST_STOP: begin
                sda_drv = (phase != Q3);
                scl_drv = ~phase[1];
                if (bit_end) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            nack     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            rem      <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            ack_bit  <= 1'b0;
            wr_sel   <= WR_DEV_W;
        end else begin
            // Pad drivers are registered so SDA/SCL never glitch on decode.
            sda_oe   <= sda_drv;
            scl_oe   <= scl_drv;
            rd_valid <= 1'b0;
            if (state == ST_IDLE && start) begin
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                rem     <= rd_len;
                nack    <= 1'b0;
                bit_cnt <= '0;
            end
            if (smp) begin
                if (state == ST_WR_ACK) ack_bit <= sda_in;
                if (state == ST_RD_BYTE) shift <= {shift[6:0], sda_in};
            end
            if (bit_end) begin
                unique case (state)
                    ST_START: begin
                        shift  <= {dev_q, I2C_WR};
                        wr_sel <= WR_DEV_W;
                    end
                    ST_RSTART: begin
                        shift  <= {dev_q, I2C_RD};
                        wr_sel <= WR_DEV_R;
                    end
                    ST_WR_BYTE: begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_WR_ACK: begin
                        if (ack_bit) nack <= 1'b1;
                        else if (wr_sel == WR_DEV_W) begin
                            shift  <= reg_q;
                            wr_sel <= WR_REG;
                        end
                    end
                    ST_RD_BYTE: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rd_data  <= shift;
                            rd_valid <= 1'b1;
                        end
                    end
                    ST_RD_ACK: rem <= rem - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
